hht_vbuf_drain: RTL and testbench
=================================

// Module: hht_vbuf_drain
// PURPOSE
//  Downstream stage of the HHT gather controller. Buffers gathered vector values v[col[i]] in a FIFO.
//  Serves them to the CPU when it issues loads to a fixed mailbox address.
//  Tracks progress against the row/column size and flags completion.
//  Stalls the CPU load when no value is ready yet.
// PARAMETERS
//  DEPTH     8     FIFO entries, power of 2, >=2
//  DW        32    data width
//  BUF_ADDR  126   CPU address mapped to the FIFO pop port
// PORTS
//  Clk          in   1     clock, rising edge
//  Rst          in   1     asynchronous reset, active-high
//  start        in   1     1-cycle pulse: latch csize, clear counters, enter STREAM
//  csize        in   32    number of elements expected for this pass
//  wn           in   1     push strobe from gather controller
//  dataIn       in   DW    gathered value
//  full         out  1     FIFO full; producer must hold wn/dataIn
//  RD           in   1     CPU load strobe
//  cpu_addr     in   32    CPU load address
//  dataOut      out  DW    popped value, registered
//  dout_valid   out  1     dataOut valid (1 cycle)
//  stall        out  1     CPU load to BUF_ADDR cannot be served this cycle
//  empty        out  1     FIFO empty
//  count        out  $clog2(DEPTH)+1  current occupancy
//  done         out  1     1-cycle pulse when the last of csize values is popped
//  stall_cycles out  32    stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, except empty=1.
//   - Pointers, counters and push/pop tallies cleared.
//   - State = IDLE.
//  States:
//   - IDLE:
//     - start&&csize!=0 -> STREAM.
//     - start&&csize==0 -> DONE, done pulses next cycle.
//   - STREAM:
//     - push accepted iff wn && !full; push_cnt++.
//     - push_cnt==csize -> DRAIN.
//   - DRAIN:
//     - pushes ignored.
//     - pop_cnt==csize -> DONE, done pulses 1 cycle.
//   - DONE:
//     - start -> STREAM (new pass, csize relatched).
//     - otherwise hold.
//  Pop request: RD && cpu_addr==BUF_ADDR, in STREAM or DRAIN.
//   - If !empty: pop, pop_cnt++, dataOut/dout_valid registered next cycle (latency 1).
//   - If empty: stall=1 combinationally the same cycle; no pop; CPU re-issues.
//  stall is never asserted in IDLE/DONE.
//   - RD to BUF_ADDR in IDLE/DONE returns dataOut=0 with dout_valid=1, no pop.
//  Simultaneous push+pop:
//   - Non-empty, non-full: both occur, count unchanged.
//   - Full: push rejected (full evaluated before pop); pop occurs.
//   - Empty: push occurs, pop stalls (no bypass).
//  Pointers wrap modulo DEPTH. count range 0..DEPTH. full = (count==DEPTH).
//  Pushes beyond csize, or outside STREAM, are dropped silently.
//  start mid-pass:
//   - FIFO flushed, tallies cleared, csize relatched, -> STREAM.
//   - No done pulse.
//  Rst mid-operation: immediate clear to reset values.
//  push_cnt/pop_cnt are 32-bit unsigned; compare exact equality with latched csize.
// CONFIGURATION
//  HHT_STALL_STATS_EN:
//   - Defined: stall_cycles counts cycles with stall=1.
//     - Cleared on Rst and on start.
//     - Saturates at 32'hFFFFFFFF.
//   - Undefined: stall_cycles tied to 0, no counter logic.
// STRUCTURE
//  Package hht_pkg:
//   - typedef enum logic[1:0] {IDLE,STREAM,DRAIN,DONE} vbuf_state_t
//   - localparam HHT_DW=32
//   - localparam HHT_BUF_ADDR=32'd126
//  Sub-module hht_sync_fifo: storage array, pointers, count, full/empty.
//  Top: FSM, address decode, tallies, stall, stats.
// TESTING
//  1. Rst=1 then 0, no stimulus -> empty=1, full=0, stall=0, done=0, dataOut=0.
//  2. start csize=3; push 5,7,10; RD@126 x3
//     -> dataOut 5,7,10 on consecutive cycles; done pulses after third pop.
//  3. DEPTH=8, csize=51; push 8 values with no pops
//     -> full=1; 9th push held off; pop one -> full=0; held value accepted.
//  4. start csize=2; RD@126 with FIFO empty
//     -> stall=1 that cycle; push 9 -> next RD returns 9, stall=0.
//     With HHT_STALL_STATS_EN: stall_cycles=1.
//  5. csize=4; push 4 values; push 5th value 99
//     -> dropped; state DRAIN; exactly 4 pops, done after 4th.
//  6. Assert Rst after 3 pushes
//     -> count=0, empty=1, state IDLE; a following RD@126 has no stall.
//     start csize=0 -> done pulse.

Source files
------------

// File: rtl/hht_pkg.sv
// Shared types and defaults for the HHT gather-controller drain stage.
package hht_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} vbuf_state_t;

    localparam int          HHT_DW       = 32;
    localparam logic [31:0] HHT_BUF_ADDR = 32'd126;
endpackage

// File: rtl/hht_sync_fifo.sv
// Single-clock FIFO holding gathered vector values; head word visible for the
// owner to register on pop. flush empties it in one cycle.
module hht_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
endmodule

// File: rtl/hht_vbuf_drain.sv
// Drain stage: buffers gathered values and serves them to CPU loads at a mailbox
// address. Optional stall statistics are enabled with HHT_STALL_STATS_EN.
module hht_vbuf_drain
    import hht_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter int          DW       = HHT_DW,
    parameter logic [31:0] BUF_ADDR = HHT_BUF_ADDR
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [31:0]            csize,
    input  logic                   wn,
    input  logic [DW-1:0]          dataIn,
    output logic                   full,
    input  logic                   RD,
    input  logic [31:0]            cpu_addr,
    output logic [DW-1:0]          dataOut,
    output logic                   dout_valid,
    output logic                   stall,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done,
    output logic [31:0]            stall_cycles
);
    vbuf_state_t   state;
    logic [31:0]   csize_reg;
    logic [31:0]   push_cnt;
    logic [31:0]   pop_cnt;
    logic [DW-1:0] fifo_head;
    logic          in_pass;
    logic          rd_hit;
    logic          push;
    logic          pop;
    logic          last_push;
    logic          last_pop;

    assign in_pass   = (state == STREAM) || (state == DRAIN);
    assign rd_hit    = RD && (cpu_addr == BUF_ADDR);
    // full/empty are sampled before this cycle's pop/push: no bypass either way.
    assign push      = !start && (state == STREAM) && wn && !full;
    assign pop       = !start && in_pass && rd_hit && !empty;
    assign stall     = !start && in_pass && rd_hit && empty;
    assign last_push = push && ((push_cnt + 32'd1) == csize_reg);
    assign last_pop  = pop && ((pop_cnt + 32'd1) == csize_reg);

    hht_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .wdata (dataIn),
        .rdata (fifo_head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            csize_reg  <= '0;
            push_cnt   <= '0;
            pop_cnt    <= '0;
            dataOut    <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            done       <= 1'b0;
            if (start) begin
                csize_reg <= csize;
                push_cnt  <= '0;
                pop_cnt   <= '0;
                state     <= (csize == 32'd0) ? DONE : STREAM;
                done      <= (csize == 32'd0);
            end else begin
                if (push) push_cnt <= push_cnt + 32'd1;
                if (pop)  pop_cnt  <= pop_cnt + 32'd1;
                if (pop) begin
                    dataOut    <= fifo_head;
                    dout_valid <= 1'b1;
                end else if (rd_hit && !in_pass) begin
                    dataOut    <= '0;
                    dout_valid <= 1'b1;
                end
                if (last_pop) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else if (last_push) begin
                    state <= DRAIN;
                end
            end
        end
    end

`ifdef HHT_STALL_STATS_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_reg <= '0;
        end else if (start) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`else
    assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hht_vbuf_drain.sv
// Randomized bench for hht_vbuf_drain against a queue-based reference model.
module tb_hht_vbuf_drain;
    localparam int DEPTH = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] csize = '0;
    logic        wn = 1'b0;
    logic [31:0] dataIn = '0;
    logic        full;
    logic        RD = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] dataOut;
    logic        dout_valid;
    logic        stall;
    logic        empty;
    logic [3:0]  count;
    logic        done;
    logic [31:0] stall_cycles;

    hht_vbuf_drain #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .csize(csize), .wn(wn),
        .dataIn(dataIn), .full(full), .RD(RD), .cpu_addr(cpu_addr),
        .dataOut(dataOut), .dout_valid(dout_valid), .stall(stall),
        .empty(empty), .count(count), .done(done), .stall_cycles(stall_cycles)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a pass is "open" once started until csize values are popped.
    logic [31:0] q[$];
    logic        started = 1'b0;
    int unsigned m_csize = 0;
    int unsigned pushed  = 0;
    int unsigned popped  = 0;
    int unsigned m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit pass_done();
        return started && (popped == m_csize);
    endfunction

    task automatic step(input bit st, input logic [31:0] cs, input bit w,
                        input logic [31:0] d, input bit rd, input logic [31:0] addr);
        bit          rd_hit, in_pass, e_stall, do_pop, do_push, e_valid, e_done;
        logic [31:0] e_data;
        @(negedge Clk);
        start = st; csize = cs; wn = w; dataIn = d; RD = rd; cpu_addr = addr;
        rd_hit  = rd && (addr == 32'd126);
        in_pass = started && (popped < m_csize);
        e_stall = !st && rd_hit && in_pass && (q.size() == 0);
        do_pop  = !st && rd_hit && in_pass && (q.size() > 0);
        do_push = !st && w && started && (pushed < m_csize) && (q.size() < DEPTH);
        e_valid = !st && rd_hit && !e_stall;
        e_data  = do_pop ? q[0] : 32'd0;
        e_done  = st ? (cs == 0) : (do_pop && (popped + 1 == m_csize));
        #1;
        chk("full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
        chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("count", {28'd0, count}, q.size());
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        if (st) begin
            q.delete(); started = 1'b1; m_csize = cs; pushed = 0; popped = 0; m_stall = 0;
        end else begin
            if (do_pop)  begin void'(q.pop_front()); popped++; end
            if (do_push) begin q.push_back(d); pushed++; end
            if (e_stall) m_stall++;
        end
        @(posedge Clk);
        #1;
        chk("dout_valid", {31'd0, dout_valid}, {31'd0, e_valid});
        if (e_valid) chk("dataOut", dataOut, e_data);
        chk("done", {31'd0, done}, {31'd0, e_done});
`ifdef HHT_STALL_STATS_EN
        chk("stall_cycles", stall_cycles, m_stall);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; start = 0; wn = 0; RD = 0;
        #1;
        q.delete(); started = 1'b0; m_csize = 0; pushed = 0; popped = 0; m_stall = 0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout",  dataOut, 32'd0);
        chk("rst_stats", stall_cycles, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    localparam logic [31:0] BA = 32'd126;

    initial begin
        do_reset();
        // Basic three-value pass.
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        step(0, 0, 1, 7, 1, BA);
        step(0, 0, 1, 10, 1, BA);
        step(0, 0, 0, 0, 1, BA);
        step(0, 0, 0, 0, 1, BA);
        // Fill to full, hold the 9th, pop to make room.
        step(1, 51, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h100 + i, 0, 0);
        step(0, 0, 1, 32'h1FF, 0, 0);
        step(0, 0, 1, 32'h1FF, 1, BA);
        step(0, 0, 1, 32'h1FF, 0, 0);
        // Stall on empty, then serve.
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, BA);
        step(0, 0, 1, 9, 0, 0);
        step(0, 0, 0, 0, 1, BA);
        // Surplus push dropped in DRAIN.
        step(1, 4, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h40 + i, 0, 0);
        step(0, 0, 1, 99, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, BA);
        // Reset mid-pass, RD with no stall, zero-size pass.
        step(1, 6, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h70 + i, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 1, BA);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, BA);

        for (int p = 0; p < 40; p++) begin
            int unsigned cs;
            int          budget;
            cs = (p % 5 == 2) ? $urandom_range(20, 40) : $urandom_range(0, 12);
            step(1, cs, 0, 0, 0, 0);
            budget = 400;
            while (!pass_done() && budget > 0) begin
                bit          w, r;
                logic [31:0] a;
                w = ($urandom_range(0, 99) < 55);
                r = ($urandom_range(0, 99) < ((p % 3 == 0) ? 25 : 50));
                a = ($urandom_range(0, 9) == 0) ? 32'd125 : BA;
                step(0, 0, w, $urandom, r, a);
                budget--;
                if (p % 7 == 3 && budget == 390) break;
                if (p % 11 == 5 && budget == 392) begin do_reset(); break; end
            end
            if (budget == 0) chk("pass_timeout", 32'd0, 32'd1);
            if (pass_done()) step(0, 0, 1, $urandom, 1, BA);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
